// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_ctrl
// Description : Receive-path controller. It turns frame_decode byte pulses
//               into a buffered, back-pressurable beat stream with first/last
//               framing and a folded error flag. It has an optional CRC_A
//               residue check, built only when RX_CRC_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_enable,
  input  logic       soc,
  input  logic       eoc,
  input  logic       data_valid,
  input  logic       sequence_error,
  input  logic       parity_error,
  input  logic [7:0] data,
  input  logic [2:0] data_bits,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits,
  output logic       out_first,
  output logic       out_last,
  output logic       out_error,
  output logic       out_crc_ok,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rx_overrun
);

  localparam int                c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                c_ENTRY_W = 15;
  localparam logic [c_PTR_W:0]  c_FULL    = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Staging and frame-status registers
  logic [7:0] r_stg_data;
  logic [2:0] r_stg_bits;
  logic       r_stg_valid;
  logic       r_first_pend;
  logic       r_err;
  logic       r_abort;
  logic       r_overrun;

  // Beat FIFO
  logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic [c_ENTRY_W-1:0] w_push_entry;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 w_start;
  logic                 w_stage;
  logic                 w_byte_drop;
  logic                 w_frame_drop;
  logic                 w_dec_err;
  logic                 w_crc_ok;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  assign w_head  = r_mem[r_rd_ptr];

`ifdef RX_CRC_CHECK_EN
  logic [15:0] r_crc;
  logic [1:0]  r_full_cnt;
  logic        r_partial;

  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Full-byte count saturates at 3: the check only needs "at least three".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc      <= 16'h6363;
      r_full_cnt <= 2'd0;
      r_partial  <= 1'b0;
    end else if (w_start) begin
      r_crc      <= 16'h6363;
      r_full_cnt <= 2'd0;
      r_partial  <= 1'b0;
    end else if (r_state == S_RECV && data_valid) begin
      if (data_bits == 3'd0) begin
        r_crc <= crc_a_byte(r_crc, data);
        if (r_full_cnt != 2'd3) r_full_cnt <= r_full_cnt + 2'd1;
      end else begin
        r_partial <= 1'b1;
      end
    end
  end

  assign w_crc_ok = (r_crc == 16'h0000) && (r_full_cnt == 2'd3) && !r_partial && !r_err;
`else
  assign w_crc_ok = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_start      = 1'b0;
    w_stage      = 1'b0;
    w_byte_drop  = 1'b0;
    w_frame_drop = 1'b0;
    w_dec_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (soc && rx_enable) begin
          w_start     = 1'b1;
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        // After a decode error the frame is already lost; later bytes are ignored.
        if (data_valid && !r_abort) begin
          w_stage = 1'b1;
          if (r_stg_valid) begin
            if (w_full) begin
              w_byte_drop = 1'b1;
            end else begin
              w_push       = 1'b1;
              w_push_entry = {r_stg_data, r_stg_bits, r_first_pend, 1'b0, 1'b0, 1'b0};
            end
          end
        end
        if (sequence_error || parity_error) w_dec_err = 1'b1;
        if (eoc) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (soc) w_frame_drop = 1'b1;
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_stg_valid)
            w_push_entry = {r_stg_data, r_stg_bits, r_first_pend, 1'b1, r_err, w_crc_ok};
          else
            w_push_entry = {8'h00, 3'd0, r_first_pend, 1'b1, 1'b1, 1'b0};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stg_data   <= 8'h00;
      r_stg_bits   <= 3'd0;
      r_stg_valid  <= 1'b0;
      r_first_pend <= 1'b0;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_overrun <= w_byte_drop | w_frame_drop;
      if (w_start) begin
        r_stg_valid  <= 1'b0;
        r_first_pend <= 1'b1;
        r_err        <= 1'b0;
        r_abort      <= 1'b0;
      end else if (r_state == S_RECV) begin
        if (w_stage) begin
          r_stg_data  <= data;
          r_stg_bits  <= data_bits;
          r_stg_valid <= 1'b1;
        end
        if (w_push)      r_first_pend <= 1'b0;
        if (w_byte_drop) r_err        <= 1'b1;
        // A byte with a decode error is discarded, so the frame ends on an empty error beat.
        if (w_dec_err) begin
          r_err       <= 1'b1;
          r_abort     <= 1'b1;
          r_stg_valid <= 1'b0;
        end
      end else if (r_state == S_FLUSH && w_push) begin
        r_stg_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are forced to zero while empty so reset and idle look clean.
  assign out_valid     = !w_empty;
  assign out_data      = w_empty ? 8'h00 : w_head[14:7];
  assign out_data_bits = w_empty ? 3'd0  : w_head[6:4];
  assign out_first     = !w_empty && w_head[3];
  assign out_last      = !w_empty && w_head[2];
  assign out_error     = !w_empty && w_head[1];
  assign out_crc_ok    = !w_empty && w_head[0];
  assign rx_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_ctrl
// Description : Directed self-checking bench for rx_frame_ctrl (FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_enable;
  logic       soc, eoc, data_valid, sequence_error, parity_error;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;
  logic       out_first, out_last, out_error, out_crc_ok, out_valid;
  logic       out_ready;
  logic       rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] beats[$];
  int          ovr_cnt = 0;

`ifdef RX_CRC_CHECK_EN
  localparam logic c_CRC_EXP = 1'b1;
`else
  localparam logic c_CRC_EXP = 1'b0;
`endif

  rx_frame_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_enable      (rx_enable),
    .soc            (soc),
    .eoc            (eoc),
    .data_valid     (data_valid),
    .sequence_error (sequence_error),
    .parity_error   (parity_error),
    .data           (data),
    .data_bits      (data_bits),
    .out_data       (out_data),
    .out_data_bits  (out_data_bits),
    .out_first      (out_first),
    .out_last       (out_last),
    .out_error      (out_error),
    .out_crc_ok     (out_crc_ok),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .rx_overrun     (rx_overrun)
  );

  always #5 clk = ~clk;

  // Beats and overrun pulses are captured mid-cycle, ahead of the popping edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      beats.push_back({out_data, out_data_bits, out_first, out_last, out_error, out_crc_ok});
    if (rst_n && rx_overrun) ovr_cnt++;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_soc();
    soc = 1'b1;
    step();
    soc = 1'b0;
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1;
    step();
    eoc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] b, input logic pe, input logic with_eoc);
    data = d; data_bits = b; data_valid = 1'b1; parity_error = pe; eoc = with_eoc;
    step();
    data = 8'h00; data_bits = 3'd0; data_valid = 1'b0; parity_error = 1'b0; eoc = 1'b0;
  endtask

  function automatic logic [14:0] head();
    return {out_data, out_data_bits, out_first, out_last, out_error, out_crc_ok};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (head() !== 15'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0000", head()); end
    n_tests++;
    if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reqa();
    beats.delete();
    out_ready = 1'b0;
    pulse_soc();
    send_byte(8'h26, 3'd7, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reqa_eoc_plus1: got valid %b expected 0", out_valid); end
    step();
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reqa_eoc_plus2: got valid %b expected 1", out_valid); end
    n_tests++;
    if (head() !== {8'h26, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL reqa_beat: got %h expected %h", head(), {8'h26, 3'd7, 4'b1100}); end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h26)
      begin n_fail++; $display("FAIL reqa_hold: got valid %b data %h expected 1 26", out_valid, out_data); end
    out_ready = 1'b1;
    step(2);
    n_tests++;
    if (out_valid !== 1'b0 || beats.size() != 1)
      begin n_fail++; $display("FAIL reqa_drain: got valid %b beats %0d expected 0 1", out_valid, beats.size()); end
  endtask

  task automatic test_anticoll();
    beats.delete();
    out_ready = 1'b1;
    pulse_soc();
    send_byte(8'h93, 3'd0, 1'b0, 1'b0);
    send_byte(8'h20, 3'd0, 1'b0, 1'b0);
    n_tests++;
    if (head() !== {8'h93, 3'd0, 4'b1000} || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL anticoll_b0: got %h expected %h", head(), {8'h93, 3'd0, 4'b1000}); end
    pulse_eoc();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL anticoll_eoc_plus1: got valid %b expected 0", out_valid); end
    step();
    n_tests++;
    if (head() !== {8'h20, 3'd0, 4'b0100} || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL anticoll_last: got %h expected %h", head(), {8'h20, 3'd0, 4'b0100}); end
    step(2);
    n_tests++;
    if (beats.size() != 2) begin n_fail++; $display("FAIL anticoll_count: got %0d expected 2", beats.size()); end
  endtask

  task automatic test_hlta(input logic [7:0] crc_hi, input logic exp_ok);
    logic [7:0] bytes [4];
    bytes[0] = 8'h50; bytes[1] = 8'h00; bytes[2] = 8'h57; bytes[3] = crc_hi;
    beats.delete();
    out_ready = 1'b1;
    pulse_soc();
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 3'd0, 1'b0, 1'b0);
    pulse_eoc();
    step(3);
    n_tests++;
    if (beats.size() != 4) begin n_fail++; $display("FAIL hlta_count_%h: got %0d expected 4", crc_hi, beats.size()); end
    n_tests++;
    if (beats[0] !== {8'h50, 3'd0, 4'b1000})
      begin n_fail++; $display("FAIL hlta_first_%h: got %h expected %h", crc_hi, beats[0], {8'h50, 3'd0, 4'b1000}); end
    n_tests++;
    if (beats[3] !== {crc_hi, 3'd0, 1'b0, 1'b1, 1'b0, exp_ok})
      begin n_fail++; $display("FAIL hlta_last_%h: got %h expected %h", crc_hi, beats[3], {crc_hi, 3'd0, 3'b010, exp_ok}); end
  endtask

  task automatic test_parity();
    beats.delete();
    out_ready = 1'b1;
    pulse_soc();
    send_byte(8'h11, 3'd0, 1'b0, 1'b0);
    send_byte(8'h22, 3'd0, 1'b1, 1'b0);
    send_byte(8'h33, 3'd0, 1'b0, 1'b0);
    pulse_eoc();
    step(3);
    n_tests++;
    if (beats.size() != 2) begin n_fail++; $display("FAIL parity_count: got %0d expected 2", beats.size()); end
    n_tests++;
    if (beats[0] !== {8'h11, 3'd0, 4'b1000})
      begin n_fail++; $display("FAIL parity_b0: got %h expected %h", beats[0], {8'h11, 3'd0, 4'b1000}); end
    n_tests++;
    if (beats[1] !== {8'h00, 3'd0, 4'b0110})
      begin n_fail++; $display("FAIL parity_last: got %h expected %h", beats[1], {8'h00, 3'd0, 4'b0110}); end
  endtask

  task automatic test_overrun();
    beats.delete();
    ovr_cnt   = 0;
    out_ready = 1'b0;
    pulse_soc();
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 3'd0, 1'b0, 1'b0);
    pulse_eoc();
    step(3);
    n_tests++;
    if (ovr_cnt != 2) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 2", ovr_cnt); end
    n_tests++;
    if (head() !== {8'h01, 3'd0, 4'b1000} || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL overrun_hold: got %h expected %h", head(), {8'h01, 3'd0, 4'b1000}); end
    out_ready = 1'b1;
    step(8);
    n_tests++;
    if (beats.size() != 5) begin n_fail++; $display("FAIL overrun_count: got %0d expected 5", beats.size()); end
    n_tests++;
    if (beats[3] !== {8'h04, 3'd0, 4'b0000})
      begin n_fail++; $display("FAIL overrun_b4: got %h expected %h", beats[3], {8'h04, 3'd0, 4'b0000}); end
    n_tests++;
    if (beats[4] !== {8'h07, 3'd0, 4'b0110})
      begin n_fail++; $display("FAIL overrun_last: got %h expected %h", beats[4], {8'h07, 3'd0, 4'b0110}); end
  endtask

  task automatic test_flush_soc();
    beats.delete();
    ovr_cnt   = 0;
    out_ready = 1'b0;
    pulse_soc();
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h40 + i), 3'd0, 1'b0, 1'b0);
    pulse_eoc();
    step();
    pulse_soc();
    send_byte(8'h99, 3'd0, 1'b0, 1'b1);
    step(2);
    n_tests++;
    if (ovr_cnt != 1) begin n_fail++; $display("FAIL flush_soc_pulse: got %0d expected 1", ovr_cnt); end
    out_ready = 1'b1;
    step(8);
    n_tests++;
    if (beats.size() != 5) begin n_fail++; $display("FAIL flush_soc_count: got %0d expected 5", beats.size()); end
    n_tests++;
    if (beats[4] !== {8'h45, 3'd0, 4'b0100})
      begin n_fail++; $display("FAIL flush_soc_last: got %h expected %h", beats[4], {8'h45, 3'd0, 4'b0100}); end
  endtask

  task automatic test_rx_enable();
    beats.delete();
    out_ready = 1'b1;
    rx_enable = 1'b0;
    pulse_soc();
    rx_enable = 1'b1;
    send_byte(8'h77, 3'd0, 1'b0, 1'b0);
    send_byte(8'h78, 3'd0, 1'b0, 1'b1);
    step(3);
    n_tests++;
    if (beats.size() != 0) begin n_fail++; $display("FAIL rx_disabled: got %0d beats expected 0", beats.size()); end
    pulse_soc();
    rx_enable = 1'b0;
    send_byte(8'h41, 3'd4, 1'b0, 1'b1);
    step(3);
    rx_enable = 1'b1;
    n_tests++;
    if (beats.size() != 1 || beats[0] !== {8'h41, 3'd4, 4'b1100})
      begin n_fail++; $display("FAIL rx_enable_fall: got %0d beats %h expected 1 %h", beats.size(), beats[0], {8'h41, 3'd4, 4'b1100}); end
  endtask

  task automatic test_reset_midframe();
    beats.delete();
    ovr_cnt   = 0;
    out_ready = 1'b0;
    pulse_soc();
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), 3'd0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got valid %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || head() !== 15'h0 || rx_overrun !== 1'b0)
      begin n_fail++; $display("FAIL midrst_async: got valid %b head %h expected 0 0000", out_valid, head()); end
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send_byte(8'hA3, 3'd0, 1'b0, 1'b1);
    step(3);
    n_tests++;
    if (out_valid !== 1'b0 || beats.size() != 0)
      begin n_fail++; $display("FAIL midrst_after: got valid %b beats %0d expected 0 0", out_valid, beats.size()); end
  endtask

  initial begin
    rst_n = 1'b0; rx_enable = 1'b1; soc = 1'b0; eoc = 1'b0; data_valid = 1'b0;
    sequence_error = 1'b0; parity_error = 1'b0; data = 8'h00; data_bits = 3'd0; out_ready = 1'b0;
    test_reset();
    test_reqa();
    test_anticoll();
    test_hlta(8'hCD, c_CRC_EXP);
    test_hlta(8'hCC, 1'b0);
    test_parity();
    test_overrun();
    test_flush_soc();
    test_rx_enable();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
